// File: rtl/mvu_sched_pkg.sv
// mvu_sched_pkg: shared widths, lane state encoding and job descriptor for the MVU scheduler.
package mvu_sched_pkg;
    localparam int AW = 9;
    localparam int MW = 2;
    localparam int PW = 3;
    localparam int CW = 12;

    typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} lane_st_e;

    typedef struct packed {
        logic [AW-1:0] base;
        logic [AW-1:0] len;
        logic [PW-1:0] prec;
        logic [MW-1:0] mode;
    } job_t;
endpackage

// File: rtl/mvu_lane_seq.sv
// mvu_lane_seq: one MVU lane sequencer (IDLE->CLR->RUN->DRAIN->DONE) with registered
// clr/sh/mulmode/raddr/busy outputs.
module mvu_lane_seq import mvu_sched_pkg::*; #(
    parameter int LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  job_t          job_i,
    input  logic          ack,
    output logic          clr,
    output logic          sh,
    output logic [MW-1:0] mulmode,
    output logic [AW-1:0] raddr,
    output logic          busy,
    output logic          idle,
    output logic          done
);
    lane_st_e      st_q, st_d;
    job_t          job_q, job_d;
    logic [AW-1:0] w_q, w_d, raddr_q, raddr_d;
    logic [PW-1:0] p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] mode_q, mode_d;
    logic          clr_q, clr_d, sh_q, sh_d, busy_q, busy_d;

    always_comb begin
        st_d  = st_q;
        job_d = job_q;
        w_d   = w_q;
        p_d   = p_q;
        cnt_d = cnt_q;
        case (st_q)
            IDLE: if (start) begin
                st_d  = CLR;
                job_d = job_i;
            end
            CLR: begin
                st_d = RUN;
                w_d  = '0;
                p_d  = '0;
            end
            RUN: if (w_q == job_q.len) begin
                w_d = '0;
                if (p_q == job_q.prec) begin
                    st_d  = DRAIN;
                    cnt_d = '0;
                end else begin
                    p_d = p_q + 1'b1;
                end
            end else begin
                w_d = w_q + 1'b1;
            end
            DRAIN: if (cnt_q == CW'(LAT - 1)) st_d = DONE; else cnt_d = cnt_q + 1'b1;
            DONE: if (ack) st_d = IDLE;
            default: st_d = IDLE;
        endcase
        // Outputs are computed from the next state so they land in the same cycle as the state.
        clr_d   = st_d == CLR;
        busy_d  = st_d != IDLE;
        sh_d    = st_d == RUN && w_d == '0 && p_d != '0;
        mode_d  = st_d == IDLE ? '0 : job_d.mode;
        raddr_d = st_d != RUN ? raddr_q : st_q == RUN ? raddr_q + 1'b1 : job_q.base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            job_q   <= '0;
            w_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            raddr_q <= '0;
            clr_q   <= 1'b0;
            sh_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            job_q   <= job_d;
            w_q     <= w_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            raddr_q <= raddr_d;
            clr_q   <= clr_d;
            sh_q    <= sh_d;
            busy_q  <= busy_d;
        end
    end

    assign clr     = clr_q;
    assign sh      = sh_q;
    assign mulmode = mode_q;
    assign raddr   = raddr_q;
    assign busy    = busy_q;
    assign idle    = st_q == IDLE;
    assign done    = st_q == DONE;
endmodule

// File: rtl/mvu_job_sched.sv
// mvu_job_sched: round-robin job dispatch and completion arbitration over N MVU lanes.
// Define MVU_SCHED_PERF_EN to add per-lane saturating busy-cycle counters (perf_clr/perf_busy).
module mvu_job_sched import mvu_sched_pkg::*; #(
    parameter int N = 8,
    parameter int LAT = 4,
    localparam int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            job_valid,
    output logic            job_ready,
    input  logic [AW-1:0]   job_base,
    input  logic [AW-1:0]   job_len,
    input  logic [PW-1:0]   job_prec,
    input  logic [MW-1:0]   job_mode,
    output logic            done_valid,
    input  logic            done_ready,
    output logic [LW-1:0]   done_lane,
    output logic [N-1:0]    clr,
    output logic [N-1:0]    sh,
    output logic [MW*N-1:0] mulmode,
    output logic [AW*N-1:0] raddr,
`ifdef MVU_SCHED_PERF_EN
    input  logic            perf_clr,
    output logic [32*N-1:0] perf_busy,
`endif
    output logic [N-1:0]    busy
);
    job_t          job;
    logic [N-1:0]  idle, done_vec, start, ack;
    logic [LW-1:0] dsel, rsel, dptr_q, dptr_d, rptr_q, rptr_d;
    logic          disp, rel;

    // First set bit at or after ptr, scanning upward with wrap.
    function automatic logic [LW-1:0] rr_pick(input logic [N-1:0] v, input logic [LW-1:0] ptr);
        logic [LW-1:0] r;
        int idx;
        r = ptr;
        for (int j = N - 1; j >= 0; j--) begin
            idx = (int'(ptr) + j) % N;
            if (v[idx]) r = LW'(idx);
        end
        return r;
    endfunction

    function automatic logic [LW-1:0] rr_next(input logic [LW-1:0] x);
        return LW'((int'(x) + 1) % N);
    endfunction

    assign job = '{base: job_base, len: job_len, prec: job_prec, mode: job_mode};

    always_comb begin
        dsel       = rr_pick(idle, dptr_q);
        rsel       = rr_pick(done_vec, rptr_q);
        job_ready  = |idle;
        done_valid = |done_vec;
        done_lane  = rsel;
        disp       = job_valid && job_ready;
        rel        = done_valid && done_ready;
        dptr_d     = disp ? rr_next(dsel) : dptr_q;
        rptr_d     = rel ? rr_next(rsel) : rptr_q;
        for (int j = 0; j < N; j++) begin
            start[j] = disp && dsel == LW'(j);
            ack[j]   = rel && rsel == LW'(j);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dptr_q <= '0;
            rptr_q <= '0;
        end else begin
            dptr_q <= dptr_d;
            rptr_q <= rptr_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        mvu_lane_seq #(.LAT(LAT)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start[i]),
            .job_i   (job),
            .ack     (ack[i]),
            .clr     (clr[i]),
            .sh      (sh[i]),
            .mulmode (mulmode[MW*i +: MW]),
            .raddr   (raddr[AW*i +: AW]),
            .busy    (busy[i]),
            .idle    (idle[i]),
            .done    (done_vec[i])
        );
    end

`ifdef MVU_SCHED_PERF_EN
    logic [N-1:0][31:0] perf_q, perf_d;

    always_comb begin
        for (int j = 0; j < N; j++)
            perf_d[j] = (start[j] && perf_clr) ? '0
                      : (busy[j] && perf_q[j] != '1) ? perf_q[j] + 1'b1 : perf_q[j];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_busy = perf_q;
`endif
endmodule

// File: tb/tb_mvu_job_sched.sv
// tb_mvu_job_sched: scoreboard bench; timed per-cycle expectations plus an ordered
// completion queue, both filled when jobs are driven.
module tb_mvu_job_sched;
    localparam int N = 8, LAT = 4, LW = 3;
    localparam int K_CLR = 0, K_RADDR = 1, K_SH = 2, K_MODE = 3, K_DONE = 4, K_NODONE = 5;

    typedef struct packed {int cyc; int kind; int lane; int val;} exp_t;

    logic           clk = 1'b0, rst_n = 1'b0, job_valid = 1'b0, done_ready = 1'b0;
    logic [8:0]     job_base = '0, job_len = '0;
    logic [2:0]     job_prec = '0;
    logic [1:0]     job_mode = '0;
    logic           job_ready, done_valid;
    logic [LW-1:0]  done_lane;
    logic [N-1:0]   clr, sh, busy;
    logic [2*N-1:0] mulmode;
    logic [9*N-1:0] raddr;
`ifdef MVU_SCHED_PERF_EN
    logic            perf_clr = 1'b0;
    logic [32*N-1:0] perf_busy;
`endif

    int   cyc = 0, vectors = 0, miscompares = 0;
    exp_t sb[$];
    int   dq[$];

    mvu_job_sched #(.N(N), .LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_base   (job_base),
        .job_len    (job_len),
        .job_prec   (job_prec),
        .job_mode   (job_mode),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_lane  (done_lane),
        .clr        (clr),
        .sh         (sh),
        .mulmode    (mulmode),
        .raddr      (raddr),
`ifdef MVU_SCHED_PERF_EN
        .perf_clr   (perf_clr),
        .perf_busy  (perf_busy),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_job(input int t, input int lane, input int b, input int l,
                              input int p, input int m, input bit full);
        int nl, np;
        nl = l + 1;
        np = p + 1;
        sb.push_back('{t + 1, K_CLR, lane, 1 << lane});
        if (full) begin
            for (int k = 0; k < np * nl; k++) begin
                sb.push_back('{t + 2 + k, K_RADDR, lane, (b + k) % 512});
                sb.push_back('{t + 2 + k, K_SH, lane, int'(k % nl == 0 && k / nl > 0)});
                sb.push_back('{t + 2 + k, K_MODE, lane, m});
            end
            sb.push_back('{t + 2 + np * nl + LAT, K_DONE, lane, lane});
            sb.push_back('{t + 3 + np * nl + LAT, K_NODONE, lane, 0});
        end
    endtask

    task automatic drive(input int b, input int l, input int p, input int m, output int t);
        job_valid = 1'b1;
        job_base  = 9'(b);
        job_len   = 9'(l);
        job_prec  = 3'(p);
        job_mode  = 2'(m);
        t = cyc;
    endtask

    task automatic idle_bus();
        job_valid = 1'b0;
        job_base  = 9'($urandom);
        job_len   = 9'($urandom);
        job_prec  = 3'($urandom);
        job_mode  = 2'($urandom);
    endtask

    task automatic send_job(input int b, input int l, input int p, input int m, output int t);
        @(posedge clk); #1;
        drive(b, l, p, m, t);
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                e = sb[i];
                case (e.kind)
                    K_CLR:   chk("clr", clr, e.val);
                    K_RADDR: chk("raddr", raddr[9*e.lane +: 9], e.val);
                    K_SH:    chk("sh", sh[e.lane], e.val);
                    K_MODE:  chk("mulmode", mulmode[2*e.lane +: 2], e.val);
                    K_DONE:  chk("done_timing", {done_valid, done_lane}, {1'b1, 3'(e.val)});
                    default: chk("done_cleared", done_valid, 0);
                endcase
                sb.delete(i);
            end
        end
        if (rst_n && done_valid && done_ready) begin
            chk("done_expected", dq.size() != 0, 1);
            if (dq.size() != 0) chk("done_lane", done_lane, dq.pop_front());
        end
    end

    initial begin
        int t, t0, r, seen, lane;
        idle_bus();
        repeat (2) @(posedge clk); #1;
        chk("rst_clr", clr, 0);
        chk("rst_sh", sh, 0);
        chk("rst_mulmode", mulmode, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_job_ready", job_ready, 1);
        rst_n = 1'b1;

        // Single two-plane job, then an address-wrapping job on the next lane.
        done_ready = 1'b1;
        send_job(10, 2, 1, 2, t);
        expect_job(t, 0, 10, 2, 1, 2, 1'b1);
        dq.push_back(0);
        repeat (16) @(posedge clk);
        send_job(510, 3, 0, 1, t);
        expect_job(t, 1, 510, 3, 0, 1, 1'b1);
        dq.push_back(1);
        repeat (14) @(posedge clk);

        // Reset during RUN cycle 3 of a lane-2 job.
        send_job(100, 7, 0, 3, t);
        repeat (4) @(posedge clk); #1;
        chk("pre_rst_raddr", raddr[9*2 +: 9], 103);
        chk("pre_rst_busy", busy, 8'h04);
        rst_n = 1'b0;
        #1;
        chk("arst_clr", clr, 0);
        chk("arst_sh", sh, 0);
        chk("arst_mulmode", mulmode, 0);
        chk("arst_raddr", raddr, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done_valid", done_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            seen += int'(done_valid);
        end
        chk("rst_no_done", seen, 0);
        chk("rst_job_ready", job_ready, 1);

        // Fill all lanes with completions held back, then release.
        done_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(posedge clk); #1;
            chk("fill_ready", job_ready, 1);
            drive(20 * i, 1, 0, i % 4, t);
            if (i == 0) t0 = t;
            expect_job(t, i, 0, 1, 0, 0, 1'b0);
            dq.push_back(i);
        end
        @(posedge clk); #1;
        idle_bus();
        chk("fill_not_ready", job_ready, 0);
        chk("fill_busy", busy, 8'hff);
        repeat (8) @(posedge clk); #1;
        chk("fill_done_valid", done_valid, 1);
        chk("fill_first_lane", done_lane, 0);
        done_ready = 1'b1;
        drive(300, 1, 0, 1, r);
        chk("release_cycle_not_ready", job_ready, 0);
        @(posedge clk); #1;
        chk("after_release_ready", job_ready, 1);
        expect_job(r + 1, 0, 300, 1, 0, 1, 1'b0);
        dq.push_back(0);
        @(posedge clk); #1;
        idle_bus();
        repeat (14) @(posedge clk);

        // Round-robin completion: pointer at 3 with lanes 2 and 5 done together.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(0, 0, 0, 0, t);
            expect_job(t, i, 0, 0, 0, 0, 1'b0);
            dq.push_back(i);
        end
        @(posedge clk); #1;
        idle_bus();
        repeat (12) @(posedge clk);
        done_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            lane = (3 + i) % N;
            @(posedge clk); #1;
            drive(40 * i, (lane == 2 || lane == 5) ? 0 : 63, 0, 2, t);
            if (i == 0) t0 = t;
            expect_job(t, lane, 0, 0, 0, 0, 1'b0);
        end
        @(posedge clk); #1;
        idle_bus();
        foreach (dq[i]) chk("rr_queue_empty", 1, 0);
        dq = '{5, 2, 3, 4, 6, 7, 0, 1};
        repeat (8) @(posedge clk); #1;
        chk("rr_done_valid", done_valid, 1);
        chk("rr_first_lane", done_lane, 5);
        done_ready = 1'b1;
        repeat (80) @(posedge clk);

`ifdef MVU_SCHED_PERF_EN
        // Busy-cycle counter: CLR + 1 RUN + LAT DRAIN + 2 DONE cycles.
        do_reset();
        done_ready = 1'b0;
        perf_clr = 1'b1;
        @(posedge clk); #1;
        drive(7, 0, 0, 3, t);
        expect_job(t, 0, 7, 0, 0, 3, 1'b0);
        dq.push_back(0);
        @(posedge clk); #1;
        idle_bus();
        perf_clr = 1'b0;
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            @(negedge clk);
            seen = int'(done_valid);
        end
        chk("perf_done_seen", seen, 1);
        @(posedge clk); #1;
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("perf_busy_lane0", perf_busy[31:0], 8);
        chk("perf_busy_lane1", perf_busy[63:32], 0);
`endif

        repeat (2) @(posedge clk); #1;
        chk("sb_drained", sb.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mvu_job_sched.md
Name: mvu_job_sched

Overview:
- Job scheduler and sequencer for the N-lane MVU array.
- Accepts matrix-vector job descriptors on a valid/ready port and dispatches each to an idle MVU lane, round-robin.
- Sequences that lane's clr, sh, mulmode and read address through a bit-serial pass, then reports completion on a valid/ready done port.
- Weight/vector loading (Waddr, Wen, D) is outside this block.

Parameters:
- N, 8, number of MVU lanes.
- LAT, 4, MVU read-to-accumulate pipeline depth; drain cycles after the last read.
- LW, max(1,$clog2(N)), lane index width (localparam).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- job_valid  in  1  job descriptor valid.
- job_ready  out  1  some lane is IDLE.
- job_base  in  9  first read address.
- job_len  in  9  words per bit plane minus 1 (L = job_len+1).
- job_prec  in  3  bit planes minus 1 (P = job_prec+1).
- job_mode  in  2  mulmode for the job.
- done_valid  out  1  some lane is in DONE.
- done_ready  in  1  consumer accepts the completion.
- done_lane  out  LW  lane whose O result is valid.
- clr  out  N  per-lane accumulator clear.
- sh  out  N  per-lane accumulator shift.
- mulmode  out  2N  per-lane multiply mode.
- raddr  out  9N  per-lane read address.
- busy  out  N  lane not IDLE.

Behaviour:
- Reset, asynchronous on rst_n low:
  - all lanes IDLE;
  - clr, sh, mulmode, raddr, busy all 0;
  - done_valid 0;
  - dispatch and done round-robin pointers 0.
- Reset mid-job aborts immediately, with no done reported.
- Lane FSM, states IDLE -> CLR -> RUN -> DRAIN -> DONE -> IDLE:
  - IDLE: wait for dispatch.
  - CLR: one cycle with clr[i]=1.
  - RUN: P*L cycles. Counter k runs 0..P*L-1, with plane p=k/L and word w=k%L. raddr[i] = (job_base + k) mod 512.
  - sh[i]=1 in RUN only when w==0 and p>0, i.e. the accumulator is shifted before each lower-significance plane.
  - DRAIN: LAT cycles, clr and sh 0.
  - DONE: wait for the done handshake.
- Dispatch:
  - job_ready = OR of lanes IDLE, combinational from registered state.
  - On job_valid&&job_ready, the job goes to the first IDLE lane at or after the dispatch pointer, scanning upward with wrap.
  - Pointer becomes that lane+1 mod N.
  - Descriptor is latched per lane; mulmode[2i+:2] holds job_mode until the lane returns to IDLE.
- Timing for a job accepted in cycle t:
  - clr at t+1;
  - first RUN cycle at t+2 with raddr=job_base;
  - last RUN cycle at t+1+P*L;
  - DONE entered at t+2+P*L+LAT, so done_valid is observable that cycle.
- Completion:
  - done_valid = any lane DONE.
  - done_lane is the first DONE lane at or after the done pointer.
  - On done_valid&&done_ready, that lane goes IDLE next cycle; done pointer becomes lane+1.
  - Lane O is stable while it sits in DONE.
- Outputs when not in RUN: raddr holds its last value; clr, sh and busy are registered.
- Simultaneous events:
  - A lane released by a done handshake is not dispatchable in the same cycle; it becomes eligible the next cycle.
  - Dispatch and done in the same cycle to different lanes are both honoured.
- Address wrap: base+k beyond 511 wraps to 0.
- Maximum RUN length 8*512 = 4096 cycles; counter width 12.
- Descriptor inputs are sampled only on handshake; they may change otherwise.

Optional Feature:
- Macro MVU_SCHED_PERF_EN.
- When defined:
  - adds output perf_busy (32N bits), one 32-bit saturating counter per lane;
  - a lane's counter increments every cycle that busy[i]=1;
  - counters reset to 0 on rst_n;
  - counters clear individually when a job is dispatched to that lane while input perf_clr=1 (1-bit port, also added).
- When undefined: neither port exists, and no counter logic is present.

Decomposition:
- Package mvu_sched_pkg holds:
  - lane state enum {IDLE, CLR, RUN, DRAIN, DONE};
  - address width 9, mode width 2, prec width 3, RUN counter width 12;
  - packed job descriptor struct {base, len, prec, mode}.
- Sub-module mvu_lane_seq: one lane FSM, its counters and its registered outputs, instantiated N times via generate.
- The top level keeps the two round-robin selectors and the perf counters.

Test Plan:
- Single job, base=10, len=2, prec=1, mode=2, done_ready=1:
  - clr at t+1;
  - raddr 10,11,12,13,14,15 at t+2..t+7;
  - sh=1 only at t+5;
  - mulmode=2 throughout;
  - done_valid at t+12 with done_lane=0.
- Wrap: base=510, len=3, prec=0 -> raddr 510,511,0,1.
- Fill: 8 back-to-back jobs with done_ready=0:
  - lanes 0..7 assigned in order;
  - job_ready=0 after the 8th;
  - raising done_ready releases lane 0 first, and the 9th job goes to lane 0 one cycle after release.
- Round-robin done: lanes 2 and 5 both DONE with the pointer at 3 -> done_lane=5, then 2.
- Reset mid-RUN: rst_n low at RUN cycle 3 -> all outputs 0 immediately, no done_valid after release, job_ready=1.
- MVU_SCHED_PERF_EN, job with len=0, prec=0, LAT=4 -> perf_busy lane 0 = 8 after the done handshake (CLR + 1 RUN + 4 DRAIN + 2 DONE cycles).
